// File: rtl/unified_mem_arbiter.sv
// unified_mem_arbiter: shares one memory port between an RV32I fetch unit and its load/store unit; data wins ties.
// Latency: 2 cycles from request edge to valid with a ready memory, +1 per wait cycle; misaligned data ops 1 cycle.
// Backpressure: stall is high while a request has no valid yet; mem_* fields held until mem_ready. Macro ARB_FETCH_BUF_EN adds a one-entry fetch buffer.
module unified_mem_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [31:0]       if_rdata,
  output logic              if_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [31:0]       d_wdata,
  input  logic [2:0]        d_func3,
  output logic [31:0]       d_rdata,
  output logic              d_valid,
  output logic              d_misalign,
  output logic              stall,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready
);

  localparam logic [ADDR_W-1:0] WORD_MASK = {{(ADDR_W-2){1'b1}}, 2'b00};

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_DATA = 2'd1, S_FETCH = 2'd2} state_t;
  state_t r_state, w_state_nxt;

  // registered outputs and their next values
  logic              r_mem_en, r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic [3:0]        r_mem_be;
  logic              r_if_valid, r_d_valid, r_d_misalign;
  logic [31:0]       r_if_rdata, r_d_rdata;
  logic              w_mem_en_nxt, w_mem_we_nxt;
  logic [ADDR_W-1:0] w_mem_addr_nxt;
  logic [31:0]       w_mem_wdata_nxt;
  logic [3:0]        w_mem_be_nxt;
  logic              w_if_valid_nxt, w_d_valid_nxt, w_d_misalign_nxt;
  logic [31:0]       w_if_rdata_nxt, w_d_rdata_nxt;

  // load shaping captured when the data access is accepted
  logic       r_ld_byte, r_ld_half, r_ld_uns, r_ld_we;
  logic [1:0] r_ld_lane;

  logic              w_sz_byte, w_sz_half, w_misal;
  logic [3:0]        w_st_be;
  logic [31:0]       w_st_wdata;
  logic [7:0]        w_lane_b;
  logic [15:0]       w_lane_h;
  logic [31:0]       w_ld_data;
  logic              w_idle_ok, w_take_d, w_take_if, w_buf_hit;
  logic [31:0]       w_buf_dat;
  logic [ADDR_W-1:0] w_d_word, w_if_word;

  assign w_d_word  = d_addr & WORD_MASK;
  assign w_if_word = if_addr & WORD_MASK;

  // Once a valid pulse is out, wait one IDLE cycle so the requester can drop its req before we sample again.
  assign w_idle_ok = (r_state == S_IDLE) && !r_d_valid && !r_if_valid;
  assign w_take_d  = w_idle_ok && d_req;
  assign w_take_if = w_idle_ok && !d_req && if_req;

  // Decode access size, alignment, lane enables and replicated store data; unknown func3 is a word access.
  always_comb begin
    w_sz_byte = (d_func3[1:0] == 2'b00) && !(d_we && d_func3[2]);
    w_sz_half = (d_func3[1:0] == 2'b01) && !(d_we && d_func3[2]);
    if (w_sz_byte) begin
      w_misal    = 1'b0;
      w_st_be    = 4'b0001 << d_addr[1:0];
      w_st_wdata = {4{d_wdata[7:0]}};
    end else if (w_sz_half) begin
      w_misal    = d_addr[0];
      w_st_be    = d_addr[1] ? 4'b1100 : 4'b0011;
      w_st_wdata = {2{d_wdata[15:0]}};
    end else begin
      w_misal    = |d_addr[1:0];
      w_st_be    = 4'b1111;
      w_st_wdata = d_wdata;
    end
  end

  // Select the addressed lane of the returned word and extend it to 32 bits.
  always_comb begin
    case (r_ld_lane)
      2'd0:    w_lane_b = mem_rdata[7:0];
      2'd1:    w_lane_b = mem_rdata[15:8];
      2'd2:    w_lane_b = mem_rdata[23:16];
      default: w_lane_b = mem_rdata[31:24];
    endcase
    w_lane_h = r_ld_lane[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    if (r_ld_byte) begin
      w_ld_data = r_ld_uns ? {24'd0, w_lane_b} : {{24{w_lane_b[7]}}, w_lane_b};
    end else if (r_ld_half) begin
      w_ld_data = r_ld_uns ? {16'd0, w_lane_h} : {{16{w_lane_h[15]}}, w_lane_h};
    end else begin
      w_ld_data = mem_rdata;
    end
  end

`ifdef ARB_FETCH_BUF_EN
  logic              r_buf_vld;
  logic [ADDR_W-1:0] r_buf_addr;
  logic [31:0]       r_buf_dat;

  assign w_buf_hit = w_take_if && r_buf_vld && (r_buf_addr == w_if_word);
  assign w_buf_dat = r_buf_dat;

  // Refill on every memory fetch completion; drop the entry when a store to its word completes.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_buf_vld  <= 1'b0;
      r_buf_addr <= '0;
      r_buf_dat  <= 32'd0;
    end else if ((r_state == S_FETCH) && mem_ready) begin
      r_buf_vld  <= 1'b1;
      r_buf_addr <= r_mem_addr;
      r_buf_dat  <= mem_rdata;
    end else if ((r_state == S_DATA) && mem_ready && r_mem_we && (r_mem_addr == r_buf_addr)) begin
      r_buf_vld  <= 1'b0;
    end
  end
`else
  assign w_buf_hit = 1'b0;
  assign w_buf_dat = 32'd0;
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (!reset) r_state <= S_IDLE;
    else        r_state <= w_state_nxt;
  end

  // Next state: misaligned data ops and buffer hits complete without leaving IDLE.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_take_d && !w_misal)        w_state_nxt = S_DATA;
        else if (w_take_if && !w_buf_hit) w_state_nxt = S_FETCH;
      end
      S_DATA, S_FETCH: begin
        if (mem_ready) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Output next values: launch the access from IDLE, hold it while waiting, respond on mem_ready.
  always_comb begin
    w_mem_en_nxt     = r_mem_en;
    w_mem_we_nxt     = r_mem_we;
    w_mem_addr_nxt   = r_mem_addr;
    w_mem_wdata_nxt  = r_mem_wdata;
    w_mem_be_nxt     = r_mem_be;
    w_if_valid_nxt   = 1'b0;
    w_if_rdata_nxt   = 32'd0;
    w_d_valid_nxt    = 1'b0;
    w_d_rdata_nxt    = 32'd0;
    w_d_misalign_nxt = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_take_d) begin
          if (w_misal) begin
            w_d_valid_nxt    = 1'b1;
            w_d_misalign_nxt = 1'b1;
          end else begin
            w_mem_en_nxt    = 1'b1;
            w_mem_we_nxt    = d_we;
            w_mem_addr_nxt  = w_d_word;
            w_mem_be_nxt    = w_st_be;
            w_mem_wdata_nxt = d_we ? w_st_wdata : 32'd0;
          end
        end else if (w_take_if) begin
          if (w_buf_hit) begin
            w_if_valid_nxt = 1'b1;
            w_if_rdata_nxt = w_buf_dat;
          end else begin
            w_mem_en_nxt    = 1'b1;
            w_mem_we_nxt    = 1'b0;
            w_mem_addr_nxt  = w_if_word;
            w_mem_be_nxt    = 4'b1111;
            w_mem_wdata_nxt = 32'd0;
          end
        end
      end
      S_DATA: begin
        if (mem_ready) begin
          w_mem_en_nxt  = 1'b0;
          w_mem_we_nxt  = 1'b0;
          w_d_valid_nxt = 1'b1;
          w_d_rdata_nxt = r_ld_we ? 32'd0 : w_ld_data;
        end
      end
      S_FETCH: begin
        if (mem_ready) begin
          w_mem_en_nxt   = 1'b0;
          w_if_valid_nxt = 1'b1;
          w_if_rdata_nxt = mem_rdata;
        end
      end
      default: ;
    endcase
  end

  // Output registers plus the load-shaping capture.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= 32'd0;
      r_mem_be     <= 4'd0;
      r_if_valid   <= 1'b0;
      r_if_rdata   <= 32'd0;
      r_d_valid    <= 1'b0;
      r_d_rdata    <= 32'd0;
      r_d_misalign <= 1'b0;
      r_ld_byte    <= 1'b0;
      r_ld_half    <= 1'b0;
      r_ld_uns     <= 1'b0;
      r_ld_we      <= 1'b0;
      r_ld_lane    <= 2'd0;
    end else begin
      r_mem_en     <= w_mem_en_nxt;
      r_mem_we     <= w_mem_we_nxt;
      r_mem_addr   <= w_mem_addr_nxt;
      r_mem_wdata  <= w_mem_wdata_nxt;
      r_mem_be     <= w_mem_be_nxt;
      r_if_valid   <= w_if_valid_nxt;
      r_if_rdata   <= w_if_rdata_nxt;
      r_d_valid    <= w_d_valid_nxt;
      r_d_rdata    <= w_d_rdata_nxt;
      r_d_misalign <= w_d_misalign_nxt;
      if (w_take_d) begin
        r_ld_byte <= w_sz_byte;
        r_ld_half <= w_sz_half;
        r_ld_uns  <= d_func3[2];
        r_ld_we   <= d_we;
        r_ld_lane <= d_addr[1:0];
      end
    end
  end

  assign mem_en     = r_mem_en;
  assign mem_we     = r_mem_we;
  assign mem_addr   = r_mem_addr;
  assign mem_wdata  = r_mem_wdata;
  assign mem_be     = r_mem_be;
  assign if_valid   = r_if_valid;
  assign if_rdata   = r_if_rdata;
  assign d_valid    = r_d_valid;
  assign d_rdata    = r_d_rdata;
  assign d_misalign = r_d_misalign;
  assign stall      = (d_req & ~r_d_valid) | (if_req & ~r_if_valid);

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb_unified_mem_arbiter: directed and random checks of the fetch/data memory arbiter against a behavioural model.
// Latency: inputs driven and outputs sampled on the falling edge; every wait is bounded by a cycle budget.
// Backpressure: a memory responder inside run() raises mem_ready after a chosen number of wait cycles.
module tb_unified_mem_arbiter;
  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        if_req = 1'b0;
  logic [31:0] if_addr = 32'd0;
  logic [31:0] if_rdata;
  logic        if_valid;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = 32'd0;
  logic [31:0] d_wdata = 32'd0;
  logic [2:0]  d_func3 = 3'd0;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        d_misalign;
  logic        stall;
  logic        mem_en;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata = 32'd0;
  logic        mem_ready = 1'b0;

  always #5 clk = ~clk;

  unified_mem_arbiter #(.ADDR_W(32)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_func3(d_func3),
    .d_rdata(d_rdata), .d_valid(d_valid), .d_misalign(d_misalign), .stall(stall),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  int nchk = 0;
  int nerr = 0;
  logic [31:0] mem [16];

  int          d_lat, i_lat, en_cycles, stall_err, stall_hi, fld_chg;
  logic [31:0] cap_addr, cap_wdata, got_drdata, got_irdata;
  logic [3:0]  cap_be;
  logic        cap_we, got_mis;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Access size in bytes from func3; anything not a defined load/store encoding is a word.
  function automatic int op_size(input logic we, input logic [2:0] f3);
    case (f3)
      3'd0: return 1;
      3'd1: return 2;
      3'd4: return we ? 4 : 1;
      3'd5: return we ? 4 : 2;
      default: return 4;
    endcase
  endfunction

  function automatic bit is_misal(input logic we, input logic [2:0] f3, input logic [31:0] a);
    return (int'(a[1:0]) % op_size(we, f3)) != 0;
  endfunction

  // Assemble the loaded bytes little-endian, then sign-extend arithmetically for signed sub-word loads.
  function automatic logic [31:0] exp_load(input logic [31:0] w, input logic [31:0] a, input logic [2:0] f3);
    int     n    = op_size(1'b0, f3);
    int     lane = int'(a[1:0]);
    longint v    = 0;
    for (int i = n - 1; i >= 0; i--) v = v * 256 + longint'((w >> (8 * (lane + i))) & 32'hFF);
    if (f3 < 3'd4 && n < 4 && v >= (longint'(1) << (8 * n - 1))) v = v - (longint'(1) << (8 * n));
    return v[31:0];
  endfunction

  function automatic logic [3:0] exp_be(input logic [2:0] f3, input logic [31:0] a);
    int n = op_size(1'b1, f3);
    int k = int'(a[1:0]);
    if (n == 1) return 4'(1 << k);
    if (n == 2) return 4'(3 << k);
    return 4'hF;
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [2:0] f3, input logic [31:0] wd);
    int n = op_size(1'b1, f3);
    if (n == 1) return (wd & 32'hFF) * 32'h01010101;
    if (n == 2) return (wd & 32'hFFFF) * 32'h00010001;
    return wd;
  endfunction

  task automatic model_store(input logic [31:0] a, input logic [3:0] be, input logic [31:0] wd);
    for (int i = 0; i < 4; i++) if (be[i]) mem[a[5:2]][8*i +: 8] = wd[8*i +: 8];
  endtask

  // Run the requests already driven, acting as the memory, until each has its valid pulse.
  task automatic run(input int waits, input int budget);
    bit want_d = d_req;
    bit want_i = if_req;
    bit done   = 0;
    int en_cnt = 0;
    d_lat = -1; i_lat = -1; en_cycles = 0; stall_err = 0; stall_hi = 0; fld_chg = 0;
    for (int c = 1; c <= budget && !done; c++) begin
      @(negedge clk);
      if (stall !== ((d_req && !d_valid) || (if_req && !if_valid))) stall_err++;
      if (stall === 1'b1) stall_hi++;
      if (d_valid === 1'b1) begin
        d_lat = c; got_drdata = d_rdata; got_mis = d_misalign; d_req = 1'b0;
      end
      if (if_valid === 1'b1) begin
        i_lat = c; got_irdata = if_rdata; if_req = 1'b0;
      end
      if (mem_en === 1'b1) begin
        en_cycles++; en_cnt++;
        if (en_cnt == 1) begin
          cap_addr = mem_addr; cap_wdata = mem_wdata; cap_be = mem_be; cap_we = mem_we;
        end else if ({mem_addr, mem_wdata, mem_be, mem_we} !== {cap_addr, cap_wdata, cap_be, cap_we}) begin
          fld_chg++;
        end
        mem_ready = (en_cnt > waits);
        mem_rdata = mem[mem_addr[5:2]];
      end else begin
        en_cnt = 0; mem_ready = 1'b0; mem_rdata = $urandom;
      end
      done = (!want_d || d_lat >= 0) && (!want_i || i_lat >= 0);
    end
    chk("timeout", 64'(done), 64'd1);
  endtask

  task automatic go_d(input logic we, input logic [31:0] a, input logic [31:0] wd, input logic [2:0] f3, input int waits);
    @(negedge clk);
    d_we = we; d_addr = a; d_wdata = wd; d_func3 = f3; d_req = 1'b1;
    run(waits, 40);
  endtask

  task automatic go_if(input logic [31:0] a, input int waits);
    @(negedge clk);
    if_addr = a; if_req = 1'b1;
    run(waits, 40);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ctl"}, {mem_en, mem_we, mem_be, if_valid, d_valid, d_misalign, stall}, 64'd0);
    chk({tag, "_addr"}, mem_addr, 64'd0);
    chk({tag, "_wdata"}, mem_wdata, 64'd0);
    chk({tag, "_rdata"}, {if_rdata, d_rdata}, 64'd0);
  endtask

  logic [31:0] ra, rwd, rold, sw_val;
  logic [2:0]  rf3;
  logic        rwe;
  int          rwt, bad;
  bit          rmis;

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = $urandom;
    mem[1] = 32'h00500093;
    mem[4] = 32'h80FF7F01;

    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    reset = 1'b1;

    // fetch from a non-word-aligned address, memory ready at once
    go_if(32'h6, 0);
    chk("fetch_addr", cap_addr, 64'h4);
    chk("fetch_be", cap_be, 64'hF);
    chk("fetch_rdata", got_irdata, 64'h00500093);
    chk("fetch_lat", 64'(i_lat), 64'd2);

    go_d(1'b0, 32'h13, 32'd0, 3'b000, 0);
    chk("lb_rdata", got_drdata, 64'hFFFFFF80);
    go_d(1'b0, 32'h13, 32'd0, 3'b100, 1);
    chk("lbu_rdata", got_drdata, 64'h00000080);
    chk("lbu_lat", 64'(d_lat), 64'd3);

    go_d(1'b1, 32'h22, 32'h0000BEEF, 3'b001, 0);
    chk("sh_addr", cap_addr, 64'h20);
    chk("sh_be", cap_be, 64'hC);
    chk("sh_wdata", cap_wdata, 64'hBEEFBEEF);
    chk("sh_we", cap_we, 64'd1);
    chk("sh_rdata", got_drdata, 64'd0);
    model_store(32'h22, 4'hC, 32'hBEEFBEEF);

    go_d(1'b0, 32'hA, 32'd0, 3'b010, 0);
    chk("mis_en", 64'(en_cycles), 64'd0);
    chk("mis_lat", 64'(d_lat), 64'd1);
    chk("mis_flag", got_mis, 64'd1);
    chk("mis_rdata", got_drdata, 64'd0);

    // simultaneous requests, 3 wait cycles on each access
    @(negedge clk);
    d_we = 1'b0; d_addr = 32'h10; d_func3 = 3'b010; d_req = 1'b1;
    if_addr = 32'h8; if_req = 1'b1;
    run(3, 40);
    chk("sim_dlat", 64'(d_lat), 64'd5);
    chk("sim_ilat", 64'(i_lat), 64'd11);
    chk("sim_drdata", got_drdata, 64'(mem[4]));
    chk("sim_irdata", got_irdata, 64'(mem[2]));
    chk("sim_stall_hi", 64'(stall_hi), 64'd10);
    chk("sim_stall_err", 64'(stall_err), 64'd0);

    // random loads and stores against the model memory
    for (int i = 0; i < 40; i++) begin
      ra = 32'($urandom_range(0, 63)); rf3 = 3'($urandom_range(0, 7));
      rwe = 1'($urandom_range(0, 1)); rwd = $urandom; rwt = $urandom_range(0, 3);
      rmis = is_misal(rwe, rf3, ra); rold = mem[ra[5:2]];
      go_d(rwe, ra, rwd, rf3, rwt);
      chk($sformatf("rnd%0d_mis", i), got_mis, 64'(rmis));
      chk($sformatf("rnd%0d_stall", i), 64'(stall_err), 64'd0);
      if (rmis) begin
        chk($sformatf("rnd%0d_lat", i), 64'(d_lat), 64'd1);
        chk($sformatf("rnd%0d_en", i), 64'(en_cycles), 64'd0);
        chk($sformatf("rnd%0d_rdata", i), got_drdata, 64'd0);
      end else begin
        chk($sformatf("rnd%0d_lat", i), 64'(d_lat), 64'(rwt + 2));
        chk($sformatf("rnd%0d_en", i), 64'(en_cycles), 64'(rwt + 1));
        chk($sformatf("rnd%0d_addr", i), cap_addr, 64'(ra & 32'hFFFFFFFC));
        chk($sformatf("rnd%0d_we", i), cap_we, 64'(rwe));
        chk($sformatf("rnd%0d_hold", i), 64'(fld_chg), 64'd0);
        if (rwe) begin
          chk($sformatf("rnd%0d_be", i), cap_be, 64'(exp_be(rf3, ra)));
          chk($sformatf("rnd%0d_wdata", i), cap_wdata, 64'(exp_wdata(rf3, rwd)));
          chk($sformatf("rnd%0d_rdata", i), got_drdata, 64'd0);
          model_store(ra, exp_be(rf3, ra), exp_wdata(rf3, rwd));
        end else begin
          chk($sformatf("rnd%0d_rdata", i), got_drdata, 64'(exp_load(rold, ra, rf3)));
        end
      end
    end

    // reset while a fetch waits on memory
    @(negedge clk);
    if_addr = 32'h4; if_req = 1'b1; mem_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rstmid_busy", mem_en, 64'd1);
    reset = 1'b0; if_req = 1'b0;
    @(negedge clk);
    chk_zero("rstmid");
    reset = 1'b1; mem_ready = 1'b1; mem_rdata = $urandom; bad = 0;
    repeat (4) begin
      @(negedge clk);
      if (if_valid !== 1'b0 || mem_en !== 1'b0 || d_valid !== 1'b0) bad++;
    end
    mem_ready = 1'b0;
    chk("rstmid_ignore", 64'(bad), 64'd0);

    go_if(32'h4, 0);
    chk("refetch1_lat", 64'(i_lat), 64'd2);
    chk("refetch1_rdata", got_irdata, 64'(mem[1]));
    go_if(32'h4, 0);
    chk("refetch2_rdata", got_irdata, 64'(mem[1]));
`ifdef ARB_FETCH_BUF_EN
    chk("refetch2_lat", 64'(i_lat), 64'd1);
    chk("refetch2_en", 64'(en_cycles), 64'd0);
`else
    chk("refetch2_lat", 64'(i_lat), 64'd2);
    chk("refetch2_en", 64'(en_cycles), 64'd1);
`endif

    // a store to the fetched word must be seen by the next fetch
    sw_val = $urandom;
    go_d(1'b1, 32'h4, sw_val, 3'b010, 0);
    model_store(32'h4, 4'hF, sw_val);
    go_if(32'h4, 0);
    chk("st_inval_en", 64'(en_cycles), 64'd1);
    chk("st_inval_rdata", got_irdata, 64'(sw_val));

    $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
    $finish;
  end
endmodule
